// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: FSM state encodings, baud divider helper and frame constants shared by the UART blocks
package uart_rx_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_e;
  // Rounded clock-per-sample-tick divider, clamped to at least 1
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = (clk_hz + baud * os / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running sample-tick divider, restartable so ticks realign to a start edge
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = (cnt_q == W'(DIV - 1));
  // Count 0..DIV-1, wrapping on the tick or jumping back to 0 on restart
  always_comb cnt_d = (restart || tick) ? '0 : cnt_q + W'(1);
  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled byte receiver with framing check; define UART_RX_PARITY_EN for 8E1 with parity_err
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  state_e state_q, state_d;
  logic [1:0] sync_q;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [2:0] bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic dv_q, dv_d, fe_q, fe_d;
  logic rxd_s, tick, restart, samp;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d, pe_q, pe_d;
  assign parity_err = pe_q;
`endif
  assign rxd_s      = sync_q[1];
  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );
  // Next-state and datapath: sample counter starts at 0 on the start edge, so every mid-bit lands on MID
  always_comb begin
    state_d = state_q;
    scnt_d  = tick ? ((scnt_q == LAST) ? '0 : scnt_q + SW'(1)) : scnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    restart = 1'b0;
    samp    = tick && (scnt_q == MID);
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
    pe_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          restart = 1'b1;
          scnt_d  = '0;
          bit_d   = '0;
        end
      end
      START: if (samp) state_d = rxd_s ? IDLE : DATA;
      DATA: begin
        if (samp) begin
          shreg_d = {rxd_s, shreg_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (samp) begin
          perr_d  = ^{shreg_q, rxd_s};
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (samp) begin
          state_d = rxd_s ? IDLE : BREAK;
          data_d  = rxd_s ? shreg_q : data_q;
          dv_d    = rxd_s;
          fe_d    = !rxd_s;
`ifdef UART_RX_PARITY_EN
          pe_d    = rxd_s && perr_q;
`endif
        end
      end
      BREAK: if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State, synchronizer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      scnt_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rxd};
      scnt_q  <= scnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pe_q    <= pe_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; define UART_RX_PARITY_EN to exercise the 8E1 build
module tb_uart_rx;
  localparam int BIT = 16;
  typedef struct {
    bit         err;
    bit         perr;
    logic [7:0] data;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err, busy;
  exp_t       sb[$];
  exp_t       mon_e;
  int         vectors = 0;
  int         miscompares = 0;
  always #5 clk = ~clk;
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif
  uart_rx #(.CLK_HZ(1843200), .BAUD(115200), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input bit b, input int n);
    rxd = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input bit err, input bit perr, input logic [7:0] d);
    exp_t e;
    e.err  = err;
    e.perr = perr;
    e.data = d;
    sb.push_back(e);
  endtask
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit pflip);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive((^b) ^ pflip, BIT);
`endif
    drive(stop, BIT);
  endtask
  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && (data_valid || frame_err || parity_err)) begin
      if (sb.size() == 0) begin
        check("stray_pulse", {29'd0, data_valid, frame_err, parity_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("frame_err", frame_err, mon_e.err);
        check("data_valid", data_valid, !mon_e.err);
        check("parity_err", parity_err, mon_e.perr);
        check("data_out", data_out, mon_e.data);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 0);
    check("rst_frame_err", frame_err, 0);
    drive(1'b1, 100);
    check("idle_busy", busy, 0);
    check("idle_data_out", data_out, 8'h00);
    push(0, 0, 8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("a5_busy", busy, 0);
    check("a5_pending", sb.size(), 0);
    drive(1'b0, 4);
    drive(1'b1, 4);
    check("glitch_busy_start", busy, 1);
    drive(1'b1, 20);
    check("glitch_busy_end", busy, 0);
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b0, BIT);
    rxd = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_data_out", data_out, 8'h00);
    drive(1'b1, BIT);
    push(1, 0, 8'h00);
    send_frame(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 40);
    check("break_busy", busy, 1);
    drive(1'b1, BIT);
    check("break_release", busy, 0);
    push(0, 0, 8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    drive(1'b1, 4);
    push(0, 0, 8'h00);
    push(0, 0, 8'hFF);
    push(0, 0, 8'h81);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    drive(1'b1, 8);
    check("b2b_pending", sb.size(), 0);
    check("b2b_busy", busy, 0);
`ifdef UART_RX_PARITY_EN
    push(0, 1, 8'h01);
    send_frame(8'h01, 1'b1, 1'b1);
    drive(1'b1, 8);
`endif
    check("final_pending", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
